// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction-fetch stage.
// Fetches one 32-bit word per instruction over a req/ack handshake and holds it
// for the control unit. The next PC is chosen from the control unit's pcsource.
// When the PC_FETCH_PERF_EN macro is defined, the unit also has the
// retired_cnt and fetch_wait_cnt performance counters.
// AW is fixed at 32; the jump and branch arithmetic assume a 32-bit PC.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          AW       = 32
) (
    input  logic          clock,
    input  logic          resetn,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [31:0]   imem_rdata,
    input  logic          stall,
    input  logic [1:0]    pcsource,
    output logic [31:0]   inst,
    output logic [11:0]   op,
    output logic          inst_valid,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] pc4
`ifdef PC_FETCH_PERF_EN
    ,
    output logic [31:0]   retired_cnt,
    output logic [31:0]   fetch_wait_cnt
`endif
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t        state_reg;
    state_t        state_next;
    logic [AW-1:0] pc_reg;
    logic [AW-1:0] pc_next;
    logic [31:0]   inst_reg;
    logic [AW-1:0] pc4_val;
    logic [AW-1:0] branch_target;
    logic [AW-1:0] jump_target;
    logic [AW-1:0] sel_pc;
    logic          fetch_done;
    logic          issue_exit;

    // Handshake outputs are pure decodes of the state register. Because the
    // state register resets asynchronously, imem_req drops the moment reset
    // is asserted, even in the middle of a fetch.
    assign imem_req   = (state_reg == FETCH);
    assign inst_valid = (state_reg == ISSUE);
    assign imem_addr  = pc_reg;
    assign pc         = pc_reg;
    assign pc4        = pc4_val;
    assign inst       = inst_reg;
    // op is a slice of a register, so the control unit never sees it glitch.
    assign op         = {inst_reg[31:26], inst_reg[5:0]};

    assign fetch_done = (state_reg == FETCH) && imem_ack;
    assign issue_exit = (state_reg == ISSUE) && !stall;

    // Next-PC candidates. pc4 wraps naturally at 2^32.
    assign pc4_val       = pc_reg + AW'(4);
    assign branch_target = pc4_val + {{14{inst_reg[15]}}, inst_reg[15:0], 2'b00};
    assign jump_target   = {pc4_val[AW-1:AW-4], inst_reg[25:0], 2'b00};

    // Select the next PC from pcsource; the reserved code falls back to pc+4.
    always_comb begin
        sel_pc = pc4_val;
        case (pcsource)
            2'b01:   sel_pc = branch_target;
            2'b10:   sel_pc = jump_target;
            default: sel_pc = pc4_val;
        endcase
    end

    // Next-state and next-PC logic; pcsource matters only on the ISSUE exit.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        case (state_reg)
            BOOT:  state_next = FETCH;
            FETCH: if (imem_ack) state_next = ISSUE;
            ISSUE: begin
                if (!stall) begin
                    state_next = FETCH;
                    pc_next    = sel_pc;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    // State, PC and instruction registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg <= BOOT;
            pc_reg    <= RESET_PC[AW-1:0];
            inst_reg  <= 32'h0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            if (fetch_done) begin
                inst_reg <= imem_rdata;
            end
        end
    end

`ifdef PC_FETCH_PERF_EN
    logic [31:0] retired_cnt_reg;
    logic [31:0] fetch_wait_cnt_reg;

    assign retired_cnt    = retired_cnt_reg;
    assign fetch_wait_cnt = fetch_wait_cnt_reg;

    // Count retired instructions and memory wait cycles.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            retired_cnt_reg    <= 32'h0;
            fetch_wait_cnt_reg <= 32'h0;
        end else begin
            if (issue_exit) begin
                retired_cnt_reg <= retired_cnt_reg + 32'd1;
            end
            if ((state_reg == FETCH) && !imem_ack) begin
                fetch_wait_cnt_reg <= fetch_wait_cnt_reg + 32'd1;
            end
        end
    end
`else
    logic unused_perf;
    assign unused_perf = issue_exit;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: randomized and directed checks of pc_fetch_unit against a
// transaction-level model. The model only knows the current PC and the last
// fetched instruction. Each instruction is described as (word, wait, stall,
// pcsource) and expands into the cycle-level expectations.
// PC_FETCH_PERF_EN, when defined, also enables the counter checks.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clock;
    logic        resetn;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic [1:0]  pcsource;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] inst;
    logic [11:0] op;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc4;

    // Second instance: starts at 0x1000_0040 and only ever sees a jump.
    logic        j_req;
    logic [31:0] j_addr;
    logic [31:0] j_inst;
    logic [11:0] j_op;
    logic        j_valid;
    logic [31:0] j_pc;
    logic [31:0] j_pc4;
    logic        j_ack;
    logic [31:0] j_rdata;
    logic        j_stall;
    logic [1:0]  j_pcsource;

`ifdef PC_FETCH_PERF_EN
    logic [31:0] retired_cnt;
    logic [31:0] fetch_wait_cnt;
    logic [31:0] j_retired_cnt;
    logic [31:0] j_fetch_wait_cnt;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] mpc;
    logic [31:0] exp_inst;
    int          m_ret;
    int          m_wait;

    pc_fetch_unit #(.RESET_PC(RST_PC), .AW(32)) u_dut (
        .clock(clock), .resetn(resetn),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .pcsource(pcsource),
        .inst(inst), .op(op), .inst_valid(inst_valid),
        .pc(pc), .pc4(pc4)
`ifdef PC_FETCH_PERF_EN
        , .retired_cnt(retired_cnt), .fetch_wait_cnt(fetch_wait_cnt)
`endif
    );

    pc_fetch_unit #(.RESET_PC(32'h1000_0040), .AW(32)) u_jump (
        .clock(clock), .resetn(resetn),
        .imem_req(j_req), .imem_addr(j_addr),
        .imem_ack(j_ack), .imem_rdata(j_rdata),
        .stall(j_stall), .pcsource(j_pcsource),
        .inst(j_inst), .op(j_op), .inst_valid(j_valid),
        .pc(j_pc), .pc4(j_pc4)
`ifdef PC_FETCH_PERF_EN
        , .retired_cnt(j_retired_cnt), .fetch_wait_cnt(j_fetch_wait_cnt)
`endif
    );

    assign j_ack      = 1'b1;
    assign j_rdata    = 32'h0800_0123;
    assign j_stall    = 1'b0;
    assign j_pcsource = 2'b10;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Architectural next-PC rule, written as plain arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] w,
                                               input logic [1:0] sel);
        logic [31:0] p4;
        int          off;
        p4  = cur + 32'd4;
        off = int'($signed(w[15:0]));
        case (sel)
            2'b01:   return p4 + 32'(off * 4);
            2'b10:   return {p4[31:28], w[25:0], 2'b00};
            default: return p4;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare all outputs at the falling edge,
    // then advance past the next rising edge.
    task automatic cycle(input bit a, input logic [31:0] rd, input bit st,
                         input logic [1:0] ps, input bit e_req, input bit e_valid);
        imem_ack   = a;
        imem_rdata = rd;
        stall      = st;
        pcsource   = ps;
        @(negedge clock);
        chk("imem_req", 32'(imem_req), 32'(e_req));
        chk("imem_addr", imem_addr, mpc);
        chk("inst_valid", 32'(inst_valid), 32'(e_valid));
        chk("pc", pc, mpc);
        chk("pc4", pc4, mpc + 32'd4);
        chk("inst", inst, exp_inst);
        chk("op", 32'(op), 32'({exp_inst[31:26], exp_inst[5:0]}));
`ifdef PC_FETCH_PERF_EN
        chk("retired_cnt", retired_cnt, 32'(m_ret));
        chk("fetch_wait_cnt", fetch_wait_cnt, 32'(m_wait));
`endif
        @(posedge clock);
        #1;
        if (e_req && !a) m_wait++;
    endtask

    // The single BOOT cycle: no request; a stray ack must not load inst.
    task automatic boot_cycle();
        cycle(1'($urandom), $urandom, 1'($urandom), 2'($urandom), 1'b0, 1'b0);
    endtask

    // One full instruction: w no-ack FETCH cycles, an acking FETCH cycle,
    // s stalled ISSUE cycles, then the exit ISSUE cycle using sel.
    task automatic run_instr(input logic [31:0] w, input int wt, input int st, input logic [1:0] sel);
        for (int i = 0; i <= wt; i++) begin
            cycle(i == wt, (i == wt) ? w : $urandom, 1'($urandom), 2'($urandom), 1'b1, 1'b0);
        end
        exp_inst = w;
        for (int j = 0; j <= st; j++) begin
            cycle(1'($urandom), $urandom, j < st, (j == st) ? sel : 2'($urandom), 1'b0, 1'b1);
        end
        mpc = model_next(mpc, w, sel);
        m_ret++;
        $display("[TB] instr word=%h wait=%0d stall=%0d sel=%0d -> next pc %h", w, wt, st, sel, mpc);
    endtask

    // Assert reset between clock edges and check that outputs fall immediately.
    task automatic reset_now(input string tag);
        #1 resetn = 1'b0;
        #1;
        chk({tag, "_req"}, 32'(imem_req), 32'h0);
        chk({tag, "_valid"}, 32'(inst_valid), 32'h0);
        chk({tag, "_pc"}, pc, RST_PC);
        chk({tag, "_inst"}, inst, 32'h0);
        mpc      = RST_PC;
        exp_inst = 32'h0;
        m_ret    = 0;
        m_wait   = 0;
        @(posedge clock);
        #1 resetn = 1'b1;
        boot_cycle();
    endtask

    initial begin
        logic [31:0] w;
        logic [15:0] off16;
        resetn     = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        stall      = 1'b0;
        pcsource   = 2'b00;
        mpc        = RST_PC;
        exp_inst   = 32'h0;
        m_ret      = 0;
        m_wait     = 0;

        // Reset state.
        repeat (3) @(posedge clock);
        #1;
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_valid", 32'(inst_valid), 32'h0);
        chk("rst_pc", pc, 32'h0000_0100);
        chk("rst_inst", inst, 32'h0);
        resetn = 1'b1;
        boot_cycle();

        // Back-to-back sequential fetches with same-cycle ack.
        run_instr($urandom, 0, 0, 2'b00);
        chk("seq_addr1", imem_addr, 32'h0000_0104);
        chk("jump_unit_addr", j_addr, 32'h1000_048C);
        run_instr($urandom, 0, 0, 2'b00);
        run_instr($urandom, 0, 0, 2'b00);
        chk("seq_addr3", imem_addr, 32'h0000_010C);

        // Jump to 0x200, then branch back by two words.
        run_instr({6'h02, 26'h000_0080}, 0, 0, 2'b10);
        chk("jump_to_200", imem_addr, 32'h0000_0200);
        run_instr(32'h3C00_FFFE, 1, 1, 2'b01);
        chk("branch_neg", imem_addr, 32'h0000_01FC);
        run_instr({6'h02, 26'h000_0080}, 0, 0, 2'b10);
        run_instr(32'h3C00_0003, 0, 0, 2'b01);
        chk("branch_pos", imem_addr, 32'h0000_0210);

        // Slow memory and a stall while pcsource wanders.
        run_instr($urandom, 4, 3, 2'b00);
        chk("stall_exit", imem_addr, 32'h0000_0214);

        // Branch to the top of the address space and wrap.
        off16 = 16'((-(int'(mpc) + 8)) / 4);
        run_instr({16'h1000, off16}, 0, 0, 2'b01);
        chk("to_top", imem_addr, 32'hFFFF_FFFC);
        run_instr($urandom, 0, 0, 2'b11);
        chk("wrap", imem_addr, 32'h0000_0000);

        // Reset in the middle of a fetch.
        cycle(1'b0, $urandom, 1'b0, 2'b00, 1'b1, 1'b0);
        cycle(1'b0, $urandom, 1'b0, 2'b00, 1'b1, 1'b0);
        reset_now("rst_fetch");
        run_instr($urandom, 1, 0, 2'b00);

        // Reset in the middle of an issue.
        w = $urandom;
        cycle(1'b1, w, 1'b0, 2'b00, 1'b1, 1'b0);
        exp_inst = w;
        cycle(1'b0, $urandom, 1'b1, 2'b00, 1'b0, 1'b1);
        reset_now("rst_issue");
        chk("restart_addr", imem_addr, 32'h0000_0100);

        // Random traffic.
        for (int k = 0; k < 40; k++) begin
            run_instr($urandom, $urandom_range(3, 0), $urandom_range(3, 0), 2'($urandom));
        end

`ifdef PC_FETCH_PERF_EN
        // Performance counters: five instructions, two wait cycles each.
        reset_now("rst_perf");
        for (int k = 0; k < 5; k++) begin
            run_instr($urandom, 2, $urandom_range(2, 0), 2'b00);
        end
        chk("perf_retired", retired_cnt, 32'd5);
        chk("perf_wait", fetch_wait_cnt, 32'd10);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
